keynsham_dma: RTL
=================

# keynsham_dma

Single-channel word-copy DMA engine acting as an initiator on the keynsham data bus. It reads words from a source region and writes them to a destination region. Each transaction is one request pulse followed by a wait for the responder's registered acknowledge, which is the contract honoured by the on-chip RAM and peripherals. It sits beside the CPU data port, and the bus arbiter selects between the two.

## Interface
Parameters:
- `timeout_cycles`, default 16: wait-state cycles without `d_ack` before a transaction is aborted (used only with the macro).
- `len_width`, default 16: width of the transfer-length field, in words.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; honoured only when idle.
- `src_addr` in 30: source word address, latched on an accepted `start`.
- `dst_addr` in 30: destination word address, latched on an accepted `start`.
- `len` in `len_width`: number of words to copy, latched on an accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse; also fires on abort.
- `error` out 1: sticky timeout flag; cleared by the next accepted `start`.
- `d_access` out 1: bus request; one-cycle pulse per transaction.
- `d_addr` out 30: word address, held stable from the request cycle through `d_ack`.
- `d_bytesel` out 4: constant 4'hf.
- `d_wr_val` out 32: write data; valid whenever `d_wr_en` is high.
- `d_wr_en` out 1: high only in write-request cycles.
- `d_data` in 32: read data; sampled only in a cycle where `d_ack` is high.
- `d_ack` in 1: responder acknowledge.

## Operation
FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - `start` with `len`≠0: latch src, dst and count; clear `error`; go to RD_REQ.
  - `start` with `len`=0: clear `error`; go to FIN.
- RD_REQ: drive `d_access`=1, `d_wr_en`=0, `d_addr`=src. Always go to RD_WAIT next cycle.
- RD_WAIT: drive `d_access`=0, `d_addr`=src. On `d_ack`: capture `d_data` into the data buffer and go to WR_REQ.
- WR_REQ: drive `d_access`=1, `d_wr_en`=1, `d_addr`=dst, `d_wr_val`=buffer. Go to WR_WAIT.
- WR_WAIT: drive `d_access`=0, `d_wr_en`=0. On `d_ack`:
  - src+1, dst+1, count−1;
  - count was 1 → FIN, otherwise → RD_REQ.
- FIN: `done`=1 for one cycle, then IDLE.
- Requests are one-cycle pulses because responders register `ack <= access && cs`. Holding `d_access` would trigger a second ack.
- `d_wr_en` must be 0 outside WR_REQ, because responders gate writes on `wr_en && cs` without qualifying on `access`.
- `d_ack` is ignored in IDLE, RD_REQ, WR_REQ and FIN.
- Address arithmetic is modulo 2^30: 30'h3fffffff+1 wraps to 0.
- Count is `len_width` bits wide, so the maximum transfer is 2^len_width−1 words.

## Timing
- Reset values:
  - all outputs 0 except `d_bytesel`=4'hf;
  - FSM in IDLE, counters cleared.
- Reset asserted mid-transfer aborts immediately: no `done` pulse, `error` is cleared.
- `start` accepted at edge T:
  - RD_REQ during cycle T+1;
  - with a single-cycle responder, `d_ack` arrives at T+2 and WR_REQ runs at T+3.
- Steady-state cost is 4 cycles per word with a zero-wait responder, plus 1 cycle for FIN.
- `len`=N: `done` is high in cycle T+4N+1. For `len`=0: `done` in T+1 with no bus activity.
- `start` while `busy` or in FIN: ignored, and latched state is unchanged.
- `busy` is low in the FIN cycle, so `start` may be issued the cycle after `done`.

## Configuration
- `KEYNSHAM_DMA_TIMEOUT_EN` defined:
  - a wait counter runs in RD_WAIT and WR_WAIT and resets on each new REQ;
  - `timeout_cycles` consecutive wait cycles without `d_ack` → set `error`, go to FIN (`done` pulses), and leave the remaining count unused.
- `KEYNSHAM_DMA_TIMEOUT_EN` undefined:
  - no counter is built; the engine waits indefinitely for `d_ack`;
  - `error` is tied to 0.

## Test plan
- Single word: RAM[0x10]=32'hdeadbeef; `start`, src=0x10, dst=0x20, `len`=1 → one read then one write with `d_bytesel`=4'hf; RAM[0x20]=32'hdeadbeef; `done` at T+5; `error`=0.
- Burst: `len`=4, src=0x100, dst=0x200 → read addresses 0x100..0x103 and write addresses 0x200..0x203 interleaved; each `d_access` high exactly 1 cycle; `done` at T+17.
- Zero length and busy start: `len`=0 → `done` at T+1, `d_access` never asserted. A second `start` during a 4-word transfer → ignored, only 4 words copied.
- Wrap: src=30'h3ffffffe, `len`=3 → read addresses 3ffffffe, 3fffffff, 0.
- Timeout (macro on): responder never acks → `d_access` pulses once, `error`=1 and `done` after 16 wait cycles; the next `start` clears `error`. With the macro off → engine stays busy.
- Reset mid-transfer: drop `rst_n` in RD_WAIT of word 2 of 4 → all outputs 0 asynchronously; after release, a fresh `start` completes normally.

Source files
------------

// File: rtl/keynsham_dma.sv
`timescale 1ns/1ps
// keynsham_dma
//
// Single-channel word-copy DMA initiator on the keynsham data bus.
// Each word costs one read transaction and one write transaction. Every
// transaction is a one-cycle d_access pulse followed by a wait for the
// responder's registered d_ack.
//
// Optional feature macro: KEYNSHAM_DMA_TIMEOUT_EN
//   defined   : a wait-state counter aborts a transaction after
//               timeout_cycles cycles without d_ack, sets error and ends
//               the transfer through FIN
//   undefined : no counter is built, the engine waits indefinitely and
//               error is tied low
//
// Parameters
//   timeout_cycles : wait cycles tolerated before abort (macro build only)
//   len_width      : width of the transfer length in words
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle request, honoured only in IDLE
//   src_addr, dst_addr    : word addresses, latched on an accepted start
//   len                   : word count, latched on an accepted start
//   busy                  : transfer in progress (low in FIN)
//   done                  : one-cycle completion / abort pulse
//   error                 : sticky timeout flag, cleared by next start
//   d_access              : one-cycle bus request per transaction
//   d_addr                : word address, stable from request through ack
//   d_bytesel             : constant 4'hf (full-word accesses only)
//   d_wr_val, d_wr_en     : write data and write strobe (WR_REQ only)
//   d_data, d_ack         : read data and responder acknowledge
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start
// RD_REQ  | read request pulse at src
// RD_WAIT | waiting for read ack, capture d_data on ack
// WR_REQ  | write request pulse at dst with buffered data
// WR_WAIT | waiting for write ack, advance pointers on ack
// FIN     | one-cycle done pulse

module keynsham_dma #(
  parameter int timeout_cycles = 16,
  parameter int len_width      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [29:0]          src_addr,
  input  logic [29:0]          dst_addr,
  input  logic [len_width-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 d_access,
  output logic [29:0]          d_addr,
  output logic [3:0]           d_bytesel,
  output logic [31:0]          d_wr_val,
  output logic                 d_wr_en,
  input  logic [31:0]          d_data,
  input  logic                 d_ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [29:0]          src_q, dst_q;
  logic [len_width-1:0] cnt_q;
  logic [31:0]          buf_q;
  logic                 start_acc;
  logic                 tmo;

  assign start_acc = (state == IDLE) && start;
  assign d_bytesel = 4'hf;

`ifdef KEYNSHAM_DMA_TIMEOUT_EN
  localparam int tw = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [tw-1:0] tmo_load = tw'(timeout_cycles - 1);

  logic [tw-1:0] wait_cnt;
  logic          error_q;
  logic          in_wait;

  assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);
  // Counter is reloaded in every REQ cycle, so it reaches zero on the
  // timeout_cycles-th consecutive wait cycle without an ack.
  assign tmo     = in_wait && !d_ack && (wait_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((state == RD_REQ) || (state == WR_REQ)) begin
      wait_cnt <= tmo_load;
    end else if (in_wait && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (start_acc) begin
      error_q <= 1'b0;
    end else if (tmo) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  localparam int unused_timeout_cycles = timeout_cycles;

  assign tmo   = 1'b0;
  assign error = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? FIN : RD_REQ;
        end
      end
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (d_ack) begin
          state_nxt = WR_REQ;
        end else if (tmo) begin
          state_nxt = FIN;
        end
      end
      WR_REQ:  state_nxt = WR_WAIT;
      WR_WAIT: begin
        if (d_ack) begin
          state_nxt = (cnt_q == len_width'(1)) ? FIN : RD_REQ;
        end else if (tmo) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: pointers, remaining count and data buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      if (start_acc && (len != '0)) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        cnt_q <= len;
      end
      if ((state == RD_WAIT) && d_ack) begin
        buf_q <= d_data;
      end
      // Pointer increments wrap modulo 2^30 by width.
      if ((state == WR_WAIT) && d_ack) begin
        src_q <= src_q + 30'd1;
        dst_q <= dst_q + 30'd1;
        cnt_q <= cnt_q - len_width'(1);
      end
    end
  end

  // Output decode
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    d_access = 1'b0;
    d_wr_en  = 1'b0;
    d_addr   = '0;
    d_wr_val = '0;
    case (state)
      RD_REQ: begin
        busy     = 1'b1;
        d_access = 1'b1;
        d_addr   = src_q;
      end
      RD_WAIT: begin
        busy   = 1'b1;
        d_addr = src_q;
      end
      WR_REQ: begin
        busy     = 1'b1;
        d_access = 1'b1;
        d_wr_en  = 1'b1;
        d_addr   = dst_q;
        d_wr_val = buf_q;
      end
      WR_WAIT: begin
        busy   = 1'b1;
        d_addr = dst_q;
      end
      FIN: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
